// File: rtl/time_pkg.sv
// Shared BCD time types, range constants and two-digit BCD helpers
// for the time-of-day counter.
package time_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t h2;
    bcd_t h1;
    bcd_t m2;
    bcd_t m1;
    bcd_t s2;
    bcd_t s1;
  } hhmmss_t;

  localparam int SEC_LAST     = 59;
  localparam int MIN_LAST     = 59;
  localparam int HOUR24_LAST  = 23;
  localparam int HOUR12_FIRST = 1;
  localparam int HOUR12_LAST  = 12;

  function automatic logic [7:0] bcd2_of(int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  function automatic logic [7:0] bcd2_inc(logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd2_dec(logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping FIRST..LAST with load,
// and carry/borrow flags on the wrapping step.
module bcd_mod_counter
  import time_pkg::*;
#(
  parameter int FIRST = 0,
  parameter int LAST  = 59
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [7:0] q_o,
  output logic       carry_o,
  output logic       borrow_o
);

  localparam logic [7:0] FIRST_BCD = bcd2_of(FIRST);
  localparam logic [7:0] LAST_BCD  = bcd2_of(LAST);

  logic [7:0] cnt_q, cnt_d;
  logic       up, dn;

  // Opposing requests in one cycle cancel out
  assign up = inc_i & ~dec_i;
  assign dn = dec_i & ~inc_i;

  assign carry_o  = up & (cnt_q == LAST_BCD);
  assign borrow_o = dn & (cnt_q == FIRST_BCD);
  assign q_o      = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (up) begin
      cnt_d = (cnt_q == LAST_BCD) ? FIRST_BCD : bcd2_inc(cnt_q);
    end else if (dn) begin
      cnt_d = (cnt_q == FIRST_BCD) ? LAST_BCD : bcd2_dec(cnt_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= FIRST_BCD;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/time_of_day_counter.sv
// BCD time-of-day counter: prescaler, 12h/24h, adjust, validated load.
// Optional alarm comparator enabled by WALLCLK_ALARM_EN.
module time_of_day_counter
  import time_pkg::*;
#(
  parameter int DIV      = 100000000,
  parameter int MODE_24H = 1
) (
  input  logic        CLK100MHZ,
  input  logic        RESET_BTN,
  input  logic        EN,
  input  logic        INC_MIN,
  input  logic        DEC_MIN,
  input  logic        INC_HOUR,
  input  logic        DEC_HOUR,
  input  logic        LOAD,
  input  logic [23:0] LOAD_TIME,
  input  logic        LOAD_PM,
  output logic [23:0] TIME,
  output logic        PM,
  output logic        SEC_TICK,
  output logic        MIN_WRAP,
  output logic        DAY_WRAP,
  output logic        LOAD_ERR
`ifdef WALLCLK_ALARM_EN
  ,
  input  logic [15:0] ALARM_TIME,
  input  logic        ALARM_PM,
  input  logic        ALARM_ARM,
  input  logic        ALARM_ACK,
  output logic        ALARM
`endif
);

  localparam int         CW        = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [7:0] H24_LAST  = bcd2_of(HOUR24_LAST);
  localparam logic [7:0] H12_FIRST = bcd2_of(HOUR12_FIRST);
  localparam logic [7:0] H12_LAST  = bcd2_of(HOUR12_LAST);
  localparam logic [7:0] H12_PRE   = bcd2_of(HOUR12_LAST - 1);
  localparam logic [7:0] H_RST     = (MODE_24H != 0) ? 8'h00 : H12_LAST;

  hhmmss_t       ld;
  logic [7:0]    ld_hr;
  logic          ld_dig_ok, ld_hr_ok, ld_valid, load_ok;
  logic          adj, tick_raw, tick_go;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic [7:0]    sec_q, min_q;
  logic          sec_carry, sec_borrow, min_carry, min_borrow;
  logic          min_inc, min_dec;
  logic [7:0]    h_q, h_d;
  logic          pm_q, pm_d;
  logic          h_up, h_dn;
  logic          dw_d;
  logic          st_q, mw_q, dw_q, le_q;
  logic          unused_ok;

  assign ld    = hhmmss_t'(LOAD_TIME);
  assign ld_hr = {ld.h2, ld.h1};

  assign ld_dig_ok = (ld.h1 <= 4'd9) & (ld.m1 <= 4'd9) & (ld.s1 <= 4'd9)
                   & (ld.m2 <= 4'd5) & (ld.s2 <= 4'd5);
  // With h1 <= 9, packed BCD compares in numeric order
  assign ld_hr_ok  = (MODE_24H != 0) ? (ld_hr <= H24_LAST)
                   : ((ld_hr >= H12_FIRST) & (ld_hr <= H12_LAST));
  assign ld_valid  = ld_dig_ok & ld_hr_ok;
  assign load_ok   = LOAD & ld_valid;

  assign adj      = INC_MIN | DEC_MIN | INC_HOUR | DEC_HOUR;
  assign tick_raw = EN & (cnt_q == CNT_LAST);
  assign tick_go  = ~LOAD & ~adj & (tick_raw | pend_q);

  always_comb begin
    cnt_d = cnt_q;
    if (load_ok)   cnt_d = '0;
    else if (EN)   cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
  end

  // A tick blocked by an adjust waits; one blocked by LOAD is dropped
  always_comb begin
    pend_d = 1'b0;
    if (LOAD)     pend_d = load_ok ? 1'b0 : pend_q;
    else if (adj) pend_d = pend_q | tick_raw;
  end

  assign min_inc = (~LOAD & INC_MIN) | (tick_go & sec_carry);
  assign min_dec = ~LOAD & DEC_MIN;

  bcd_mod_counter #(.FIRST(0), .LAST(SEC_LAST)) u_sec (
    .clk_i      (CLK100MHZ),
    .rst_i      (RESET_BTN),
    .load_i     (load_ok),
    .load_val_i ({ld.s2, ld.s1}),
    .inc_i      (tick_go),
    .dec_i      (1'b0),
    .q_o        (sec_q),
    .carry_o    (sec_carry),
    .borrow_o   (sec_borrow)
  );

  bcd_mod_counter #(.FIRST(0), .LAST(MIN_LAST)) u_min (
    .clk_i      (CLK100MHZ),
    .rst_i      (RESET_BTN),
    .load_i     (load_ok),
    .load_val_i ({ld.m2, ld.m1}),
    .inc_i      (min_inc),
    .dec_i      (min_dec),
    .q_o        (min_q),
    .carry_o    (min_carry),
    .borrow_o   (min_borrow)
  );

  assign unused_ok = ^{sec_borrow, min_borrow};

  assign h_up = (~LOAD & INC_HOUR & ~DEC_HOUR) | (tick_go & min_carry);
  assign h_dn = ~LOAD & DEC_HOUR & ~INC_HOUR;

  always_comb begin
    h_d  = h_q;
    pm_d = pm_q;
    dw_d = 1'b0;
    if (load_ok) begin
      h_d  = ld_hr;
      pm_d = (MODE_24H != 0) ? 1'b0 : LOAD_PM;
    end else if (h_up) begin
      if (MODE_24H != 0) begin
        if (h_q == H24_LAST) begin
          h_d  = 8'h00;
          dw_d = tick_go;
        end else begin
          h_d = bcd2_inc(h_q);
        end
      end else if (h_q == H12_LAST) begin
        h_d = H12_FIRST;
      end else if (h_q == H12_PRE) begin
        h_d  = H12_LAST;
        pm_d = ~pm_q;
        dw_d = tick_go & pm_q;
      end else begin
        h_d = bcd2_inc(h_q);
      end
    end else if (h_dn) begin
      if (MODE_24H != 0) begin
        h_d = (h_q == 8'h00) ? H24_LAST : bcd2_dec(h_q);
      end else if (h_q == H12_FIRST) begin
        h_d = H12_LAST;
      end else if (h_q == H12_LAST) begin
        h_d  = H12_PRE;
        pm_d = ~pm_q;
      end else begin
        h_d = bcd2_dec(h_q);
      end
    end
  end

  always_ff @(posedge CLK100MHZ or posedge RESET_BTN) begin
    if (RESET_BTN) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
      h_q    <= H_RST;
      pm_q   <= 1'b0;
      st_q   <= 1'b0;
      mw_q   <= 1'b0;
      dw_q   <= 1'b0;
      le_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      h_q    <= h_d;
      pm_q   <= pm_d;
      st_q   <= tick_go;
      mw_q   <= tick_go & sec_carry;
      dw_q   <= dw_d;
      le_q   <= LOAD & ~ld_valid;
    end
  end

  assign TIME     = {h_q, min_q, sec_q};
  assign PM       = (MODE_24H != 0) ? 1'b0 : pm_q;
  assign SEC_TICK = st_q;
  assign MIN_WRAP = mw_q;
  assign DAY_WRAP = dw_q;
  assign LOAD_ERR = le_q;

`ifdef WALLCLK_ALARM_EN
  logic alarm_q, alarm_d, al_hit;

  // st_q marks that the time now showing came from a tick
  assign al_hit = st_q & (TIME == {ALARM_TIME, 8'h00})
                & ((MODE_24H != 0) | (pm_q == ALARM_PM));

  always_comb begin
    alarm_d = alarm_q;
    if (ALARM_ACK | ~ALARM_ARM) alarm_d = 1'b0;
    else if (al_hit)            alarm_d = 1'b1;
  end

  always_ff @(posedge CLK100MHZ or posedge RESET_BTN) begin
    if (RESET_BTN) alarm_q <= 1'b0;
    else           alarm_q <= alarm_d;
  end

  assign ALARM = alarm_q;
`endif

endmodule

// File: tb/tb_time_of_day_counter.sv
// Scoreboard bench for time_of_day_counter: a 24h and a 12h instance
// share stimulus; each scenario task checks the instance it targets.
module tb_time_of_day_counter;

  typedef logic [28:0] ev_t;

  typedef struct packed {
    logic [4:0]  c;
    logic [23:0] ld;
    logic        lpm;
    logic [23:0] t;
    logic        pm;
  } step_t;

  typedef struct packed {
    logic [23:0] ld;
    logic [23:0] t24;
    logic        e24;
    logic [23:0] t12;
    logic        e12;
  } lerr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en, inc_m, dec_m, inc_h, dec_h, load, ld_pm;
  logic [23:0] ld_t;
  logic [23:0] t24, t12;
  logic pm24, st24, mw24, dw24, le24;
  logic pm12, st12, mw12, dw12, le12;
`ifdef WALLCLK_ALARM_EN
  logic [15:0] al_t;
  logic al_pm, al_arm, al_ack, al24, al12;
  logic al_q[$];
`endif

  ev_t exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  time_of_day_counter #(.DIV(4), .MODE_24H(1)) u24 (
    .CLK100MHZ (clk),   .RESET_BTN (rst),   .EN (en),
    .INC_MIN (inc_m),   .DEC_MIN (dec_m),
    .INC_HOUR (inc_h),  .DEC_HOUR (dec_h),
    .LOAD (load),       .LOAD_TIME (ld_t),  .LOAD_PM (ld_pm),
    .TIME (t24),        .PM (pm24),         .SEC_TICK (st24),
    .MIN_WRAP (mw24),   .DAY_WRAP (dw24),   .LOAD_ERR (le24)
`ifdef WALLCLK_ALARM_EN
    , .ALARM_TIME (al_t), .ALARM_PM (al_pm), .ALARM_ARM (al_arm),
    .ALARM_ACK (al_ack),  .ALARM (al24)
`endif
  );

  time_of_day_counter #(.DIV(4), .MODE_24H(0)) u12 (
    .CLK100MHZ (clk),   .RESET_BTN (rst),   .EN (en),
    .INC_MIN (inc_m),   .DEC_MIN (dec_m),
    .INC_HOUR (inc_h),  .DEC_HOUR (dec_h),
    .LOAD (load),       .LOAD_TIME (ld_t),  .LOAD_PM (ld_pm),
    .TIME (t12),        .PM (pm12),         .SEC_TICK (st12),
    .MIN_WRAP (mw12),   .DAY_WRAP (dw12),   .LOAD_ERR (le12)
`ifdef WALLCLK_ALARM_EN
    , .ALARM_TIME (al_t), .ALARM_PM (al_pm), .ALARM_ARM (al_arm),
    .ALARM_ACK (al_ack),  .ALARM (al12)
`endif
  );

  function automatic ev_t ev(logic [23:0] t, logic pm, logic [3:0] s);
    return {t, pm, s};
  endfunction

  function automatic ev_t obs(bit m24);
    if (m24) return {t24, pm24, st24, mw24, dw24, le24};
    return {t12, pm12, st12, mw12, dw12, le12};
  endfunction

  task automatic clr();
    {load, inc_m, dec_m, inc_h, dec_h} = 5'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ev_t e;
    cyc();
    exp_q.push_back(ev(24'h000000, 1'b0, 4'b0000));
    exp_q.push_back(ev(24'h120000, 1'b0, 4'b0000));
    e = exp_q.pop_front();
    checks++;
    if (obs(1) !== e) begin
      errors++;
      $display("FAIL reset24 got %h exp %h", obs(1), e);
    end
    e = exp_q.pop_front();
    checks++;
    if (obs(0) !== e) begin
      errors++;
      $display("FAIL reset12 got %h exp %h", obs(0), e);
    end
    @(negedge clk);
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_wrap24();
    ev_t e;
    logic [23:0] t;
    en = 1'b1; load = 1'b1; ld_t = 24'h235958;
    for (int k = 0; k <= 8; k++) begin
      t = (k < 4) ? 24'h235958 : (k < 8) ? 24'h235959 : 24'h000000;
      exp_q.push_back(ev(t, 1'b0, (k == 4) ? 4'b1000 :
                                  (k == 8) ? 4'b1110 : 4'b0000));
      cyc();
      clr();
      e = exp_q.pop_front();
      checks++;
      if (obs(1) !== e) begin
        errors++;
        $display("FAIL wrap24 cyc %0d got %h exp %h", k, obs(1), e);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_wrap12();
    ev_t e;
    for (int r = 0; r < 2; r++) begin
      en = 1'b1; load = 1'b1; ld_t = 24'h115959; ld_pm = r[0];
      for (int k = 0; k <= 4; k++) begin
        if (k < 4) exp_q.push_back(ev(24'h115959, r[0], 4'b0000));
        else exp_q.push_back(ev(24'h120000, ~r[0], r[0] ? 4'b1110 : 4'b1100));
        cyc();
        clr();
        e = exp_q.pop_front();
        checks++;
        if (obs(0) !== e) begin
          errors++;
          $display("FAIL wrap12 pm%0d cyc %0d got %h exp %h", r, k, obs(0), e);
        end
      end
      en = 1'b0;
    end
    ld_pm = 1'b0;
  endtask

  task automatic test_adjust24();
    step_t tb[10];
    ev_t e;
    tb = '{
      '{5'b10000, 24'h105930, 1'b0, 24'h105930, 1'b0},
      '{5'b01000, 24'h0,      1'b0, 24'h100030, 1'b0},
      '{5'b10000, 24'h001500, 1'b0, 24'h001500, 1'b0},
      '{5'b00001, 24'h0,      1'b0, 24'h231500, 1'b0},
      '{5'b01100, 24'h0,      1'b0, 24'h231500, 1'b0},
      '{5'b10000, 24'h230010, 1'b0, 24'h230010, 1'b0},
      '{5'b00100, 24'h0,      1'b0, 24'h235910, 1'b0},
      '{5'b00010, 24'h0,      1'b0, 24'h005910, 1'b0},
      '{5'b01010, 24'h0,      1'b0, 24'h010010, 1'b0},
      '{5'b00011, 24'h0,      1'b0, 24'h010010, 1'b0}
    };
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      {load, inc_m, dec_m, inc_h, dec_h} = tb[i].c;
      ld_t = tb[i].ld; ld_pm = tb[i].lpm;
      exp_q.push_back(ev(tb[i].t, tb[i].pm, 4'b0000));
      cyc();
      clr();
      e = exp_q.pop_front();
      checks++;
      if (obs(1) !== e) begin
        errors++;
        $display("FAIL adjust24 step %0d got %h exp %h", i, obs(1), e);
      end
    end
  endtask

  task automatic test_adjust12();
    step_t tb[6];
    ev_t e;
    tb = '{
      '{5'b10000, 24'h115000, 1'b0, 24'h115000, 1'b0},
      '{5'b00010, 24'h0,      1'b0, 24'h125000, 1'b1},
      '{5'b00010, 24'h0,      1'b0, 24'h015000, 1'b1},
      '{5'b00001, 24'h0,      1'b0, 24'h125000, 1'b1},
      '{5'b00001, 24'h0,      1'b0, 24'h115000, 1'b0},
      '{5'b00100, 24'h0,      1'b0, 24'h114900, 1'b0}
    };
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      {load, inc_m, dec_m, inc_h, dec_h} = tb[i].c;
      ld_t = tb[i].ld; ld_pm = tb[i].lpm;
      exp_q.push_back(ev(tb[i].t, tb[i].pm, 4'b0000));
      cyc();
      clr();
      e = exp_q.pop_front();
      checks++;
      if (obs(0) !== e) begin
        errors++;
        $display("FAIL adjust12 step %0d got %h exp %h", i, obs(0), e);
      end
    end
  endtask

  task automatic test_tick_collision();
    ev_t e;
    logic [23:0] t;
    en = 1'b1; load = 1'b1; ld_t = 24'h051020;
    for (int k = 0; k <= 8; k++) begin
      if (k == 4) inc_m = 1'b1;
      if (k == 6) en = 1'b0;
      t = (k < 4) ? 24'h051020 : (k == 4) ? 24'h051120 : 24'h051121;
      exp_q.push_back(ev(t, 1'b0, (k == 5) ? 4'b1000 : 4'b0000));
      cyc();
      clr();
      e = exp_q.pop_front();
      checks++;
      if (obs(1) !== e) begin
        errors++;
        $display("FAIL collide cyc %0d got %h exp %h", k, obs(1), e);
      end
    end
  endtask

  task automatic test_load_err();
    lerr_t tb[6];
    ev_t e;
    tb = '{
      '{24'h083000, 24'h083000, 1'b0, 24'h083000, 1'b0},
      '{24'h240000, 24'h083000, 1'b1, 24'h083000, 1'b1},
      '{24'h126A00, 24'h083000, 1'b1, 24'h083000, 1'b1},
      '{24'h003000, 24'h003000, 1'b0, 24'h083000, 1'b1},
      '{24'h130000, 24'h130000, 1'b0, 24'h083000, 1'b1},
      '{24'h125959, 24'h125959, 1'b0, 24'h125959, 1'b0}
    };
    en = 1'b0; ld_pm = 1'b0;
    for (int i = 0; i < 6; i++) begin
      load = 1'b1; ld_t = tb[i].ld;
      exp_q.push_back(ev(tb[i].t24, 1'b0, {3'b000, tb[i].e24}));
      exp_q.push_back(ev(tb[i].t12, 1'b0, {3'b000, tb[i].e12}));
      cyc();
      clr();
      e = exp_q.pop_front();
      checks++;
      if (obs(1) !== e) begin
        errors++;
        $display("FAIL loaderr24 step %0d got %h exp %h", i, obs(1), e);
      end
      e = exp_q.pop_front();
      checks++;
      if (obs(0) !== e) begin
        errors++;
        $display("FAIL loaderr12 step %0d got %h exp %h", i, obs(0), e);
      end
    end
  endtask

  task automatic test_reset_mid();
    ev_t e;
    en = 1'b1;
    cyc();
    cyc();
    #2 rst = 1'b1;
    #1;
    exp_q.push_back(ev(24'h000000, 1'b0, 4'b0000));
    exp_q.push_back(ev(24'h120000, 1'b0, 4'b0000));
    e = exp_q.pop_front();
    checks++;
    if (obs(1) !== e) begin
      errors++;
      $display("FAIL midreset24 got %h exp %h", obs(1), e);
    end
    e = exp_q.pop_front();
    checks++;
    if (obs(0) !== e) begin
      errors++;
      $display("FAIL midreset12 got %h exp %h", obs(0), e);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back(ev((k < 4) ? 24'h000000 : 24'h000001, 1'b0,
                         (k == 4) ? 4'b1000 : 4'b0000));
      cyc();
      e = exp_q.pop_front();
      checks++;
      if (obs(1) !== e) begin
        errors++;
        $display("FAIL prescale cyc %0d got %h exp %h", k, obs(1), e);
      end
    end
    en = 1'b0;
  endtask

`ifdef WALLCLK_ALARM_EN
  task automatic test_alarm();
    logic ea;
    al_t = 16'h0700; al_pm = 1'b0; al_arm = 1'b1; al_ack = 1'b0;
    en = 1'b1; load = 1'b1; ld_t = 24'h065958;
    for (int k = 0; k <= 11; k++) begin
      if (k == 9)  en = 1'b0;
      if (k == 10) al_ack = 1'b1;
      al_q.push_back(k == 9);
      cyc();
      clr();
      al_ack = 1'b0;
      ea = al_q.pop_front();
      checks++;
      if (al24 !== ea) begin
        errors++;
        $display("FAIL alarm_armed cyc %0d got %b exp %b", k, al24, ea);
      end
      if (k == 8) begin
        checks++;
        if (t24 !== 24'h070000) begin
          errors++;
          $display("FAIL alarm_time got %h exp 070000", t24);
        end
      end
    end
    load = 1'b1; ld_t = 24'h070000;
    for (int k = 0; k < 3; k++) begin
      al_q.push_back(1'b0);
      cyc();
      clr();
      ea = al_q.pop_front();
      checks++;
      if (al24 !== ea) begin
        errors++;
        $display("FAIL alarm_load cyc %0d got %b exp %b", k, al24, ea);
      end
    end
    al_arm = 1'b0; en = 1'b1; load = 1'b1; ld_t = 24'h065958;
    for (int k = 0; k <= 10; k++) begin
      al_q.push_back(1'b0);
      cyc();
      clr();
      ea = al_q.pop_front();
      checks++;
      if (al24 !== ea) begin
        errors++;
        $display("FAIL alarm_disarmed cyc %0d got %b exp %b", k, al24, ea);
      end
    end
    en = 1'b0;
  endtask
`endif

  initial begin
    en = 1'b0; ld_t = '0; ld_pm = 1'b0;
    clr();
`ifdef WALLCLK_ALARM_EN
    al_t = '0; al_pm = 1'b0; al_arm = 1'b0; al_ack = 1'b0;
`endif
    test_reset();
    test_wrap24();
    test_wrap12();
    test_adjust24();
    test_adjust12();
    test_tick_collision();
    test_load_err();
    test_reset_mid();
`ifdef WALLCLK_ALARM_EN
    test_alarm();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
